// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard unit: RAW/load-use stall detection against N producer
// stages, branch flush sequencing, saturating stall counter and stall watchdog.
module hazard_stall_unit #(
    parameter int REG_W     = 5,
    parameter int N_STAGES  = 2,
    parameter int FWD_EN    = 0,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [31:0]               Instruction,
    input  logic                      UsesRs,
    input  logic                      UsesRt,
    input  logic [N_STAGES*REG_W-1:0] DstVec,
    input  logic [N_STAGES-1:0]       WrVec,
    input  logic [N_STAGES-1:0]       RdVec,
    input  logic                      BranchTaken,
    output logic                      PCWrite,
    output logic                      IFIDWrite,
    output logic                      CtrlZero,
    output logic                      IFIDFlush,
    output logic                      Stall,
    output logic [CNT_W-1:0]          StallCount,
    output logic                      StallTimeout
);

    localparam int SC_W = $clog2(MAX_STALL + 1);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t            state, state_nx;
    logic [2:0]        fcnt, fcnt_nx;
    logic [REG_W-1:0]  rs, rt;
    logic [N_STAGES-1:0] match;
    logic              haz;
    logic [SC_W-1:0]   consec;
    logic [SC_W:0]     consec_inc;
    logic              unused_bits;

    assign rs          = REG_W'(Instruction[25:21]);
    assign rt          = REG_W'(Instruction[20:16]);
    assign consec_inc  = {1'b0, consec} + (SC_W+1)'(1);
    assign unused_bits = ^{Instruction[31:26], Instruction[15:0], RdVec};

    // Per-stage RAW match; register 0 and unread source fields never hazard.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < N_STAGES; i++) begin
            match[i] = WrVec[i] && (DstVec[i*REG_W +: REG_W] != '0) &&
                       ((UsesRs && (DstVec[i*REG_W +: REG_W] == rs)) ||
                        (UsesRt && (DstVec[i*REG_W +: REG_W] == rt)));
        end
        haz = (FWD_EN != 0) ? (match[0] & RdVec[0]) : (|match);
    end

    // State and flush counter register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
        end
    end

    // Next state and zero-latency outputs; reset forces the safe output set.
    always_comb begin
        state_nx  = state;
        fcnt_nx   = fcnt;
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        CtrlZero  = 1'b1;
        IFIDFlush = 1'b0;
        Stall     = 1'b0;
        if (!Rst_n) begin
            state_nx = RUN;
            fcnt_nx  = '0;
        end else if (BranchTaken) begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            IFIDFlush = 1'b1;
            if (FLUSH_CYC > 0) begin
                state_nx = FLUSH;
                fcnt_nx  = 3'(FLUSH_CYC);
            end else begin
                state_nx = RUN;
                fcnt_nx  = '0;
            end
        end else if (state == FLUSH) begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            IFIDFlush = 1'b1;
            if (fcnt <= 3'd1) begin
                state_nx = RUN;
                fcnt_nx  = '0;
            end else begin
                fcnt_nx = fcnt - 3'd1;
            end
        end else if (haz) begin
            Stall = 1'b1;
        end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            CtrlZero  = 1'b0;
        end
    end

    // Saturating total stall-cycle counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

    // Consecutive-stall watchdog; timeout is sticky until reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            consec       <= '0;
            StallTimeout <= 1'b0;
        end else if (!Stall) begin
            consec <= '0;
        end else begin
            if (consec != SC_W'(MAX_STALL)) begin
                consec <= consec_inc[SC_W-1:0];
            end
            if (consec_inc >= (SC_W+1)'(MAX_STALL)) begin
                StallTimeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit: three instances share the
// stimulus (stall-on-any-RAW, load-use-only, 4-bit counter).
module tb_hazard_stall_unit;

    localparam logic [4:0] E_RUN   = 5'b11000;  // {PCWrite,IFIDWrite,CtrlZero,IFIDFlush,Stall}
    localparam logic [4:0] E_STALL = 5'b00101;
    localparam logic [4:0] E_BR    = 5'b11110;
    localparam logic [4:0] E_RST   = 5'b00100;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] instr;
    logic        uses_rs, uses_rt, branch;
    logic [9:0]  dst_vec;
    logic [1:0]  wr_vec, rd_vec;

    logic        pcw0, ifw0, cz0, fl0, st0, to0;
    logic [15:0] cnt0;
    logic        pcw1, ifw1, cz1, fl1, st1, to1;
    logic [15:0] cnt1;
    logic        pcw2, ifw2, cz2, fl2, st2, to2;
    logic [3:0]  cnt2;

    logic [4:0] o0, o1;
    assign o0 = {pcw0, ifw0, cz0, fl0, st0};
    assign o1 = {pcw1, ifw1, cz1, fl1, st1};

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    hazard_stall_unit #(.REG_W(5), .N_STAGES(2), .FWD_EN(0), .FLUSH_CYC(1), .CNT_W(16), .MAX_STALL(8)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Instruction(instr), .UsesRs(uses_rs), .UsesRt(uses_rt),
        .DstVec(dst_vec), .WrVec(wr_vec), .RdVec(rd_vec), .BranchTaken(branch),
        .PCWrite(pcw0), .IFIDWrite(ifw0), .CtrlZero(cz0), .IFIDFlush(fl0), .Stall(st0),
        .StallCount(cnt0), .StallTimeout(to0));

    hazard_stall_unit #(.REG_W(5), .N_STAGES(2), .FWD_EN(1), .FLUSH_CYC(1), .CNT_W(16), .MAX_STALL(8)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Instruction(instr), .UsesRs(uses_rs), .UsesRt(uses_rt),
        .DstVec(dst_vec), .WrVec(wr_vec), .RdVec(rd_vec), .BranchTaken(branch),
        .PCWrite(pcw1), .IFIDWrite(ifw1), .CtrlZero(cz1), .IFIDFlush(fl1), .Stall(st1),
        .StallCount(cnt1), .StallTimeout(to1));

    hazard_stall_unit #(.REG_W(5), .N_STAGES(2), .FWD_EN(0), .FLUSH_CYC(1), .CNT_W(4), .MAX_STALL(8)) dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .Instruction(instr), .UsesRs(uses_rs), .UsesRt(uses_rt),
        .DstVec(dst_vec), .WrVec(wr_vec), .RdVec(rd_vec), .BranchTaken(branch),
        .PCWrite(pcw2), .IFIDWrite(ifw2), .CtrlZero(cz2), .IFIDFlush(fl2), .Stall(st2),
        .StallCount(cnt2), .StallTimeout(to2));

    task automatic push(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                          input logic [4:0] d0, input logic [4:0] d1, input logic [1:0] wr,
                          input logic [1:0] rd, input logic br);
        instr   = {6'd0, rs, rt, 16'h0000};
        uses_rs = urs;
        uses_rt = urt;
        dst_vec = {d1, d0};
        wr_vec  = wr;
        rd_vec  = rd;
        branch  = br;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // Assert reset between edges, check forced outputs, release 1 time unit after an edge.
    task automatic do_reset();
        Rst_n = 1'b0;
        #1;
        push("rst_out", 32'(E_RST));
        push("rst_cnt", 32'd0);
        push("rst_to", 32'd0);
        cmp(32'(o0));
        cmp(32'(cnt0));
        cmp(32'(to0));
        next_cycle();
        Rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        Rst_n = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        do_reset();

        // RAW detection, register 0, unused fields, load-use-only mode
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
        push("ex_rs_raw_o0", 32'(E_STALL)); push("ex_rs_raw_o1", 32'(E_RUN));
        #2; cmp(32'(o0)); cmp(32'(o1)); next_cycle();

        set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0);
        push("dst_zero_o0", 32'(E_RUN));
        #2; cmp(32'(o0)); next_cycle();

        set_in(5'd3, 5'd7, 1'b0, 1'b1, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
        push("rs_unused_o0", 32'(E_RUN));
        #2; cmp(32'(o0)); next_cycle();

        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 5'd0, 2'b01, 2'b00, 1'b0);
        push("ex_rt_alu_o0", 32'(E_STALL)); push("ex_rt_alu_o1", 32'(E_RUN));
        #2; cmp(32'(o0)); cmp(32'(o1)); next_cycle();

        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 5'd0, 2'b01, 2'b01, 1'b0);
        push("ex_loaduse_o0", 32'(E_STALL)); push("ex_loaduse_o1", 32'(E_STALL));
        #2; cmp(32'(o0)); cmp(32'(o1)); next_cycle();

        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 5'd5, 2'b10, 2'b10, 1'b0);
        push("mem_load_o0", 32'(E_STALL)); push("mem_load_o1", 32'(E_RUN));
        #2; cmp(32'(o0)); cmp(32'(o1)); next_cycle();

        set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 5'd5, 2'b00, 2'b10, 1'b0);
        push("mem_nowrite_o0", 32'(E_RUN));
        #2; cmp(32'(o0)); next_cycle();

        // Three stall cycles, then branch with one extra flush cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
            push("pre_branch_stall", 32'(E_STALL));
            #2; cmp(32'(o0)); next_cycle();
        end
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b1);
        push("branch_beats_haz", 32'(E_BR)); push("branch_cnt", 32'd3);
        #2; cmp(32'(o0)); cmp(32'(cnt0)); next_cycle();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
        push("flush_cycle", 32'(E_BR)); push("flush_cnt", 32'd3);
        #2; cmp(32'(o0)); cmp(32'(cnt0)); next_cycle();
        push("after_flush_run", 32'(E_STALL));
        #2; cmp(32'(o0)); next_cycle();

        // Watchdog: 7 stalls then a break must not trip; 8 consecutive must
        do_reset();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 7; i++) next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        push("to_after_7", 32'd0);
        #2; cmp(32'(to0)); next_cycle();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 7; i++) next_cycle();
        push("to_before_8th", 32'd0);
        #2; cmp(32'(to0)); next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        push("to_after_8th", 32'd1);
        #2; cmp(32'(to0)); next_cycle();
        push("to_sticky", 32'd1); push("to_sticky_out", 32'(E_RUN));
        #2; cmp(32'(to0)); cmp(32'(o0)); next_cycle();

        // Counter saturation in the 4-bit instance
        do_reset();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 15; i++) next_cycle();
        push("cnt4_at_15", 32'd15);
        #2; cmp(32'(cnt2));
        for (int i = 0; i < 5; i++) next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        push("cnt4_sat", 32'd15); push("cnt16_20", 32'd20);
        #2; cmp(32'(cnt2)); cmp(32'(cnt0)); next_cycle();

        // Asynchronous reset in the middle of a flush
        do_reset();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
        next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1);
        next_cycle();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
        push("mid_flush", 32'(E_BR)); push("mid_flush_cnt", 32'd1);
        #2; cmp(32'(o0)); cmp(32'(cnt0));
        Rst_n = 1'b0;
        #1;
        push("async_rst_out", 32'(E_RST)); push("async_rst_cnt", 32'd0);
        cmp(32'(o0)); cmp(32'(cnt0));
        next_cycle();
        Rst_n = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        push("post_rst_run", 32'(E_RUN));
        #2; cmp(32'(o0)); next_cycle();
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01, 2'b00, 1'b0);
        push("post_rst_stall", 32'(E_STALL));
        #2; cmp(32'(o0)); next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
